// File: rtl/definitions_pkg.sv
// Shared RV32I definitions: opcodes, encoder formats, error codes and request record.
package definitions_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U} enc_fmt_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_OPCODE = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;
    localparam logic [1:0] ERR_ALIGN  = 2'b11;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } instr_req_t;

    // True when v is representable as a w-bit two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int w);
        int s;
        s = $signed(v);
        return (s >= -(1 << (w - 1))) && (s < (1 << (w - 1)));
    endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational RV32I word packer: opcode -> format -> 32-bit word, plus legality verdict.
module instr_packer
    import definitions_pkg::*;
(
    input  instr_req_t  req,
    output logic [31:0] word,
    output logic [1:0]  err_code
);

    enc_fmt_t    fmt;
    logic        known;
    logic [31:0] imm;

    assign imm = req.imm;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        fmt   = FMT_I;
        known = 1'b1;
        case (req.opcode)
            OPC_OP:                          fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:  fmt = FMT_I;
            OPC_STORE:                       fmt = FMT_S;
            OPC_BRANCH:                      fmt = FMT_B;
            OPC_JAL:                         fmt = FMT_J;
            OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
            default:                         known = 1'b0;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt)
            FMT_R: word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I: begin
                // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
                if (req.opcode == OPC_OP_IMM && req.funct3[1:0] == 2'b01)
                    word = {req.funct7, imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
                else
                    word = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            end
            FMT_S: word = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
            FMT_B: word = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                           imm[4:1], imm[11], req.opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
            FMT_U: word = {imm[31:12], req.rd, req.opcode};
            default: word = '0;
        endcase
    end

    always_comb begin
        err_code = ERR_NONE;
        if (!known)
            err_code = ERR_OPCODE;
        else if (((fmt == FMT_B || fmt == FMT_J) && imm[0]) ||
                 (fmt == FMT_U && imm[11:0] != 12'h000))
            err_code = ERR_ALIGN;
        else if (((fmt == FMT_I || fmt == FMT_S) && !fits_signed(imm, 12)) ||
                 (fmt == FMT_B && !fits_signed(imm, 13)) ||
                 (fmt == FMT_J && !fits_signed(imm, 21)))
            err_code = ERR_RANGE;
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction assembler: accepts field-level requests, packs them and
// writes each legal word to instruction memory at an auto-incrementing address.
module instr_encoder
    import definitions_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  opcode_t           req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    state_t      state;
    instr_req_t  cap;
    logic [31:0] pack_word;
    logic [1:0]  pack_err;

    // count never exceeds 2^ADDR_W, so its top bit alone marks capacity reached.
    assign full      = count[ADDR_W];
    assign req_ready = (state == S_IDLE) && !full;

    instr_packer u_packer (
        .req      (cap),
        .word     (pack_word),
        .err_code (pack_err)
    );

    // NOTE: the capture register has no reset; it is only read in ENCODE, after being loaded.
    always_ff @(posedge clk) begin
        if (!clear && req_valid && req_ready)
            cap <= '{opcode: req_opcode, rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                     funct3: req_funct3, funct7: req_funct7, imm: req_imm};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (clear) begin
            state    <= S_IDLE;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready)
                        state <= S_ENCODE;
                end
                S_ENCODE: begin
                    if (pack_err != ERR_NONE) begin
                        err      <= 1'b1;
                        err_code <= pack_err;
                        state    <= S_IDLE;
                    end else begin
                        mem_wdata <= pack_word;
                        mem_we    <= 1'b1;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + ADDR_ONE;
                        if (!full)
                            count <= count + COUNT_ONE;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=2 so capacity limits are reachable).
module tb_instr_encoder;
    import definitions_pkg::*;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              req_valid;
    logic              req_ready;
    opcode_t           req_opcode;
    logic [4:0]        req_rd, req_rs1, req_rs2;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [31:0]       req_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .count      (count),
        .full       (full),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm);
        req_opcode = op;  req_rd = rd;  req_rs1 = rs1;  req_rs2 = rs2;
        req_funct3 = f3;  req_funct7 = f7;  req_imm = imm;
        req_valid  = 1'b1;
    endtask

    // Presents a request and returns at the negedge following its acceptance (ENCODE cycle).
    task automatic send(input opcode_t op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        int waited = 0;
        set_req(op, rd, rs1, rs2, f3, f7, imm);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("send_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_we(input string tag, output logic seen);
        int waited = 0;
        while (!mem_we && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        seen = mem_we;
        if (!seen) check({tag, "_we_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic expect_write(input string tag, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] data, input int delay,
                                input logic [ADDR_W:0] cnt_after);
        logic seen;
        wait_we(tag, seen);
        if (!seen) return;
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        check({tag, "_data"}, mem_wdata, data);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, "_hold_we"}, 32'(mem_we), 32'd1);
            check({tag, "_hold_data"}, mem_wdata, data);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check({tag, "_we_drop"}, 32'(mem_we), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(cnt_after));
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code,
                              input logic [ADDR_W:0] cnt);
        @(negedge clk);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_code"}, 32'(err_code), 32'(code));
        check({tag, "_no_we"}, 32'(mem_we), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(cnt));
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset = 1'b1;  clear = 1'b0;  mem_ack = 1'b0;  req_valid = 1'b0;
        req_opcode = OPC_OP;  req_rd = '0;  req_rs1 = '0;  req_rs2 = '0;
        req_funct3 = '0;  req_funct7 = '0;  req_imm = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);

        // ADDI x1,x0,5 with immediate ack
        send(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_write("addi", 2'd0, 32'h00500093, 0, 3'd1);

        // ADD then SW, ack delayed three cycles
        do_clear();
        send(OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        expect_write("add", 2'd0, 32'h002081B3, 3, 3'd1);
        send(OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        expect_write("sw", 2'd1, 32'h0020A423, 3, 3'd2);

        // Four formats fill the 4-word memory; fifth request stalls
        do_clear();
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        expect_write("beq", 2'd0, 32'hFE208EE3, 0, 3'd1);
        send(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_write("jal", 2'd1, 32'h001000EF, 0, 3'd2);
        send(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_write("lui", 2'd2, 32'h123452B7, 0, 3'd3);
        send(OPC_OP_IMM, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3);
        expect_write("srai", 2'd3, 32'h40315093, 1, 3'd4);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_wrap_addr", 32'(mem_addr), 32'd0);

        set_req(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        repeat (4) @(negedge clk);
        check("stall_we", 32'(mem_we), 32'd0);
        check("stall_count", 32'(count), 32'd4);
        do_clear();
        check("clr_count", 32'(count), 32'd0);
        check("clr_addr", 32'(mem_addr), 32'd0);
        check("clr_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        expect_write("reaccept", 2'd0, 32'h00500093, 0, 3'd1);

        // Illegal requests: never written, count held
        do_clear();
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        expect_err("ill_beq_align", 2'b11, 3'd0);
        send(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        expect_err("ill_addi_range", 2'b10, 3'd0);
        send(opcode_t'(7'h7F), 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        expect_err("ill_opcode", 2'b01, 3'd0);
        send(OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
        expect_err("ill_beq_range", 2'b10, 3'd0);
        send(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        expect_err("ill_jal_range", 2'b10, 3'd0);
        send(OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        expect_err("ill_lui_align", 2'b11, 3'd0);
        send(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        expect_write("addi_min", 2'd0, 32'h80000093, 0, 3'd1);
        check("err_sticky", 32'(err), 32'd1);
        check("err_code_kept", 32'(err_code), 32'd3);
        do_clear();
        check("clr_err", 32'(err), 32'd0);
        check("clr_err_code", 32'(err_code), 32'd0);

        // clear during WRITE with a concurrent ack
        send(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_write("pre_clr", 2'd0, 32'h00500093, 0, 3'd1);
        send(OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        wait_we("clr_wr", seen);
        check("clr_wr_addr", 32'(mem_addr), 32'd1);
        clear = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mem_ack = 1'b0;
        check("clr_wr_we", 32'(mem_we), 32'd0);
        check("clr_wr_addr0", 32'(mem_addr), 32'd0);
        check("clr_wr_count", 32'(count), 32'd0);

        // asynchronous reset during WRITE
        send(OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        expect_write("pre_rst", 2'd0, 32'h00500093, 0, 3'd1);
        send(OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        wait_we("rst_wr", seen);
        mem_ack = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_wr_we", 32'(mem_we), 32'd0);
        check("rst_wr_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_count", 32'(count), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
